scan_chain_ctrl: RTL and testbench

//  Sequencer for a W-bit register bank built from dff cells, with one shared serial scan path.

---
 rtl/scan_chain_pkg.sv | 38 +++
 rtl/scan_cell.sv | 36 +++
 rtl/scan_chain_ctrl.sv | 140 ++++++++++++++
 tb/tb_scan_chain_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/scan_chain_pkg.sv
// Shared definitions for the scan chain sequencer: FSM state encoding,
// operation codes, per-cell data select and small op-decoding helpers.
package scan_chain_pkg;

  // FSM states; encoding is fixed so the state can be probed externally.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_CAP   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Host operation codes, sampled together with start.
  typedef enum logic [1:0] {
    OP_LOAD    = 2'b00,
    OP_CAPTURE = 2'b01,
    OP_UNLOAD  = 2'b10,
    OP_SWAP    = 2'b11
  } op_t;

  // Data select for every bank cell; all cells share one select.
  typedef enum logic [1:0] {
    SEL_HOLD  = 2'd0,
    SEL_SHIFT = 2'd1,
    SEL_CAP   = 2'd2
  } cell_sel_t;

  // Operations that feed si into the chain.
  function automatic logic op_shifts_in(input op_t o);
    return (o == OP_LOAD) || (o == OP_SWAP);
  endfunction

  // Operations that present the chain LSB on so.
  function automatic logic op_shifts_out(input op_t o);
    return (o == OP_UNLOAD) || (o == OP_SWAP);
  endfunction

endpackage

// File: rtl/scan_cell.sv
// One bit of the scan bank: a dff whose D input selects between holding
// its value, taking the serial neighbour, or taking the parallel input.
// Cleared asynchronously by nR.
module scan_cell
  import scan_chain_pkg::*;
(
  input  logic      C,
  input  logic      nR,
  input  cell_sel_t sel,
  input  logic      d_shift,
  input  logic      d_cap,
  output logic      q
);

  logic r_q;
  logic w_d;

  // D-input mux: the unused select code falls back to hold.
  always_comb begin
    w_d = r_q;
    case (sel)
      SEL_SHIFT: w_d = d_shift;
      SEL_CAP:   w_d = d_cap;
      default:   w_d = r_q;
    endcase
  end

  // Storage flop with asynchronous clear.
  always_ff @(posedge C or negedge nR) begin
    if (!nR) r_q <= 1'b0;
    else     r_q <= w_d;
  end

  assign q = r_q;

endmodule

// File: rtl/scan_chain_ctrl.sv
// Sequencer for a W-bit dff register bank with a single serial scan path.
// Runs LOAD, CAPTURE, UNLOAD and SWAP; owns the bank's data-select muxing.
// Optional feature macro: SCAN_PARITY_EN adds a trailing even-parity bit
// to LOAD/SWAP streams and a par_err output.
module scan_chain_ctrl
  import scan_chain_pkg::*;
#(
  parameter int W     = 8,
  parameter int CNT_W = 4
) (
  input  logic         C,
  input  logic         nR,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic         si,
  input  logic [W-1:0] pin,
  output logic         so,
  output logic [W-1:0] pout,
  output logic         busy,
  output logic         done
`ifdef SCAN_PARITY_EN
  ,
  output logic         par_err
`endif
);

  state_t           r_state;
  op_t              r_op;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_done;

  logic [W-1:0]     w_q;
  logic [W-1:0]     w_shift_d;
  logic             w_din;
  logic             w_par_cycle;
  logic [CNT_W-1:0] w_last;
  cell_sel_t        w_sel;

`ifdef SCAN_PARITY_EN
  logic r_par_err;

  // LOAD/SWAP take one extra cycle to consume the parity bit; that cycle
  // must leave the bank untouched.
  assign w_last      = op_shifts_in(r_op) ? CNT_W'(W) : CNT_W'(W - 1);
  assign w_par_cycle = (r_cnt == CNT_W'(W));
  assign par_err     = r_par_err;
`else
  assign w_last      = CNT_W'(W - 1);
  assign w_par_cycle = 1'b0;
`endif

  // Serial input into the MSB: host data for LOAD/SWAP, zero fill for UNLOAD.
  assign w_din     = op_shifts_in(r_op) ? si : 1'b0;
  assign w_shift_d = {w_din, w_q[W-1:1]};

  // Bank data select derived from the registered state only.
  always_comb begin
    w_sel = SEL_HOLD;
    case (r_state)
      ST_SHIFT: w_sel = w_par_cycle ? SEL_HOLD : SEL_SHIFT;
      ST_CAP:   w_sel = SEL_CAP;
      default:  w_sel = SEL_HOLD;
    endcase
  end

  // The bank itself: W identical cells on one shared select.
  for (genvar gi = 0; gi < W; gi++) begin : g_cell
    scan_cell u_cell (
      .C       (C),
      .nR      (nR),
      .sel     (w_sel),
      .d_shift (w_shift_d[gi]),
      .d_cap   (pin[gi]),
      .q       (w_q[gi])
    );
  end

  // Control FSM with shift counter and registered busy/done.
  always_ff @(posedge C or negedge nR) begin
    if (!nR) begin
      r_state   <= ST_IDLE;
      r_op      <= OP_LOAD;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
`ifdef SCAN_PARITY_EN
      r_par_err <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_op   <= op_t'(op);
            r_cnt  <= '0;
            r_busy <= 1'b1;
`ifdef SCAN_PARITY_EN
            r_par_err <= 1'b0;
`endif
            r_state <= (op_t'(op) == OP_CAPTURE) ? ST_CAP : ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == w_last) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
`ifdef SCAN_PARITY_EN
            // Bank now holds all W data bits; si carries the parity bit.
            if (op_shifts_in(r_op)) r_par_err <= (^w_q) ^ si;
`endif
          end
        end
        ST_CAP: begin
          r_state <= ST_DONE;
          r_done  <= 1'b1;
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Serial out is the bank LSB only while an unloading op is shifting data.
  assign so   = (r_state == ST_SHIFT) && op_shifts_out(r_op) && !w_par_cycle
                ? w_q[0] : 1'b0;
  assign pout = w_q;
  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Directed self-checking bench for scan_chain_ctrl (W=8).
// Define SCAN_PARITY_EN when building to exercise the parity variant.
module tb_scan_chain_ctrl;

  localparam int W     = 8;
  localparam int CNT_W = 4;

  logic         C;
  logic         nR;
  logic         start;
  logic [1:0]   op;
  logic         si;
  logic [W-1:0] pin;
  logic         so;
  logic [W-1:0] pout;
  logic         busy;
  logic         done;
`ifdef SCAN_PARITY_EN
  logic         par_err;
`endif

  int errors = 0;
  int checks = 0;

  scan_chain_ctrl #(.W(W), .CNT_W(CNT_W)) dut (
    .C     (C),
    .nR    (nR),
    .start (start),
    .op    (op),
    .si    (si),
    .pin   (pin),
    .so    (so),
    .pout  (pout),
    .busy  (busy),
    .done  (done)
`ifdef SCAN_PARITY_EN
    ,
    .par_err (par_err)
`endif
  );

  initial C = 1'b0;
  always #5 C = ~C;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle before sampling.
  task automatic step();
    @(posedge C);
    #1;
  endtask

  initial begin
    logic [7:0] v;
    logic [7:0] so_exp;
    int         done_seen;

    nR = 1'b0; start = 1'b0; op = 2'b00; si = 1'b0; pin = '0;
    step(); step();
    check("rst_pout", 32'(pout), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_so",   32'(so),   32'h0);
`ifdef SCAN_PARITY_EN
    check("rst_par_err", 32'(par_err), 32'h0);
`endif
    nR = 1'b1;
    step();

    // LOAD 8'hA5 LSB first
    v = 8'hA5;
    start = 1'b1; op = 2'b00;
    step();
    start = 1'b0;
    check("load_busy", 32'(busy), 32'h1);
    check("load_done_early", 32'(done), 32'h0);
    for (int i = 0; i < W; i++) begin
      si = v[i];
      check("load_so_zero", 32'(so), 32'h0);
      step();
      if (i == W - 2) check("load_done_not_yet", 32'(done), 32'h0);
    end
`ifdef SCAN_PARITY_EN
    check("load_no_done_before_parity", 32'(done), 32'h0);
    si = ^v;
    step();
`endif
    check("load_done", 32'(done), 32'h1);
    check("load_pout", 32'(pout), 32'hA5);
    step();
    check("load_done_once", 32'(done), 32'h0);
    check("load_busy_clr", 32'(busy), 32'h0);

    // CAPTURE 8'h3C, pin change after capture has no effect
    pin = 8'h3C; start = 1'b1; op = 2'b01;
    step();
    start = 1'b0;
    check("cap_busy", 32'(busy), 32'h1);
    step();
    pin = 8'hFF;
    check("cap_done", 32'(done), 32'h1);
    check("cap_pout", 32'(pout), 32'h3C);
    step();
    check("cap_idle_busy", 32'(busy), 32'h0);
    check("cap_pout_hold", 32'(pout), 32'h3C);

    // UNLOAD; op/si changes mid-op ignored (zero fill)
    so_exp = 8'h3C;
    start = 1'b1; op = 2'b10;
    step();
    start = 1'b0; op = 2'b00; si = 1'b1;
    for (int i = 0; i < W; i++) begin
      check($sformatf("unload_so%0d", i), 32'(so), 32'(so_exp[i]));
      step();
    end
    check("unload_done", 32'(done), 32'h1);
    check("unload_pout", 32'(pout), 32'h0);
    check("unload_so_after", 32'(so), 32'h0);
    step();
    si = 1'b0;

    // SWAP: bank F0 out, 0F in
    pin = 8'hF0; start = 1'b1; op = 2'b01;
    step(); start = 1'b0;
    step(); step();
    check("swap_pre_pout", 32'(pout), 32'hF0);
    so_exp = 8'hF0; v = 8'h0F;
    start = 1'b1; op = 2'b11;
    step();
    start = 1'b0;
    for (int i = 0; i < W; i++) begin
      si = v[i];
      check($sformatf("swap_so%0d", i), 32'(so), 32'(so_exp[i]));
      step();
    end
`ifdef SCAN_PARITY_EN
    check("swap_so_parity_cycle", 32'(so), 32'h0);
    si = ^v;
    step();
`endif
    check("swap_done", 32'(done), 32'h1);
    check("swap_pout", 32'(pout), 32'h0F);
    step();

    // start held high: one CAPTURE per pass through IDLE
    pin = 8'h55; start = 1'b1; op = 2'b01;
    step();
    check("hold_busy", 32'(busy), 32'h1);
    step();
    check("hold_done1", 32'(done), 32'h1);
    check("hold_pout1", 32'(pout), 32'h55);
    pin = 8'hAA;
    step();
    check("hold_idle_busy", 32'(busy), 32'h0);
    check("hold_idle_pout", 32'(pout), 32'h55);
    step();
    check("hold_restart_busy", 32'(busy), 32'h1);
    step();
    check("hold_done2", 32'(done), 32'h1);
    check("hold_pout2", 32'(pout), 32'hAA);
    start = 1'b0;
    step();

    // Asynchronous reset mid-UNLOAD of 8'hAA
    start = 1'b1; op = 2'b10;
    step();
    start = 1'b0;
    check("abort_so_b0", 32'(so), 32'h0);
    step();
    check("abort_so_b1", 32'(so), 32'h1);
    #2;
    nR = 1'b0;
    #1;
    check("abort_pout", 32'(pout), 32'h0);
    check("abort_busy", 32'(busy), 32'h0);
    check("abort_so",   32'(so),   32'h0);
    done_seen = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (done) done_seen++;
    end
    nR = 1'b1;
    for (int i = 0; i < W + 2; i++) begin
      step();
      if (done) done_seen++;
    end
    check("abort_no_done", 32'(done_seen), 32'h0);
    check("abort_idle_busy", 32'(busy), 32'h0);
    check("abort_pout_idle", 32'(pout), 32'h0);

`ifdef SCAN_PARITY_EN
    // LOAD 8'h07 with correct parity (1), then wrong parity (0)
    for (int pass = 0; pass < 2; pass++) begin
      v = 8'h07;
      start = 1'b1; op = 2'b00;
      step();
      start = 1'b0;
      check("par_cleared_on_start", 32'(par_err), 32'h0);
      for (int i = 0; i < W; i++) begin
        si = v[i];
        step();
      end
      si = (pass == 0) ? 1'b1 : 1'b0;
      step();
      check("par_done", 32'(done), 32'h1);
      check("par_pout", 32'(pout), 32'h07);
      check($sformatf("par_err_pass%0d", pass), 32'(par_err), (pass == 0) ? 32'h0 : 32'h1);
      step(); step(); step();
    end
    check("par_err_held", 32'(par_err), 32'h1);
    pin = 8'h11; start = 1'b1; op = 2'b01;
    step();
    start = 1'b0;
    check("par_err_clr_start", 32'(par_err), 32'h0);
    step(); step();
    check("par_err_capture", 32'(par_err), 32'h0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
